// File: rtl/note_sequencer.sv
// Timed note source: FIFO of {note, duration} entries played back one at a time
// onto the organ's 7-bit note input, with an optional rest gap between notes.
module note_sequencer #(
  parameter int unsigned CLK_PER_TICK = 100000,
  parameter int unsigned GAP_TICKS    = 0,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DUR_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 in_note,
  input  logic [DUR_W-1:0]           in_dur,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       flush,
  output logic [6:0]                 note,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PRE_W = $clog2(CLK_PER_TICK);
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 2);
  localparam int unsigned CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t                 state;
  logic                   run;
  logic [PRE_W-1:0]       prescale;
  logic [CNT_W-1:0]       tick_cnt;

  logic [7+DUR_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [7+DUR_W-1:0]     head;
  logic [6:0]             head_note;
  logic [DUR_W-1:0]       head_dur;

  logic push, pop, tick, more, timing;

  assign in_ready  = (level != LVL_W'(DEPTH));
  assign busy      = (state != IDLE);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = (state == LOAD) && !stop && (level != '0);
  assign head      = mem[rd_ptr];
  assign head_note = head[DUR_W +: 7];
  assign head_dur  = head[DUR_W-1:0];
  assign timing    = (state == PLAY) || (state == GAP);
  assign tick      = timing && (prescale == PRE_W'(CLK_PER_TICK - 1));
  assign more      = run && (level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_note, in_dur};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      run      <= 1'b0;
      note     <= '0;
      done     <= 1'b0;
      prescale <= '0;
      tick_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (stop)       run <= 1'b0;
      else if (start) run <= 1'b1;

      if (timing) prescale <= tick ? '0 : prescale + PRE_W'(1);
      else        prescale <= '0;

      if (stop) begin
        state <= IDLE;
        note  <= '0;
      end else begin
        case (state)
          IDLE: begin
            note <= '0;
            if (more) state <= LOAD;
          end
          LOAD: begin
            // A flush racing the decision can leave LOAD facing an empty FIFO.
            if (level == '0) begin
              state <= IDLE;
              note  <= '0;
            end else if (head_dur == '0) begin
              if (!(level > LVL_W'(1) && !flush)) begin
                state <= IDLE;
                note  <= '0;
              end
            end else begin
              note     <= head_note;
              tick_cnt <= CNT_W'(head_dur);
              state    <= PLAY;
            end
          end
          PLAY: begin
            if (tick) begin
              if (tick_cnt == CNT_W'(1)) begin
                if (GAP_TICKS != 0) begin
                  state    <= GAP;
                  note     <= '0;
                  tick_cnt <= CNT_W'(GAP_TICKS);
                end else if (more) begin
                  state <= LOAD;
                end else begin
                  state <= IDLE;
                  note  <= '0;
                  done  <= 1'b1;
                end
              end else begin
                tick_cnt <= tick_cnt - CNT_W'(1);
              end
            end
          end
          GAP: begin
            if (tick) begin
              if (tick_cnt == CNT_W'(1)) begin
                if (more) begin
                  state <= LOAD;
                end else begin
                  state <= IDLE;
                  done  <= 1'b1;
                end
              end else begin
                tick_cnt <= tick_cnt - CNT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: legato instance plus a one-tick-gap instance.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0, start = 1'b0, stop = 1'b0, flush = 1'b0;
  logic [6:0] in_note = '0;
  logic [7:0] in_dur = '0;
  logic       in_ready, busy, done;
  logic [6:0] note;
  logic [2:0] level;

  logic       g_in_valid = 1'b0, g_start = 1'b0, g_stop = 1'b0, g_flush = 1'b0;
  logic [6:0] g_in_note = '0;
  logic [7:0] g_in_dur = '0;
  logic       g_in_ready, g_busy, g_done;
  logic [6:0] g_note;
  logic [2:0] g_level;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  note_sequencer #(.CLK_PER_TICK(4), .GAP_TICKS(0), .DEPTH(4), .DUR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_note(in_note), .in_dur(in_dur), .start(start), .stop(stop), .flush(flush),
    .note(note), .busy(busy), .done(done), .level(level)
  );

  note_sequencer #(.CLK_PER_TICK(4), .GAP_TICKS(1), .DEPTH(4), .DUR_W(8)) dut_gap (
    .clk(clk), .rst(rst), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .in_note(g_in_note), .in_dur(g_in_dur), .start(g_start), .stop(g_stop), .flush(g_flush),
    .note(g_note), .busy(g_busy), .done(g_done), .level(g_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_note", note, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 1);

    // legato playback of {60,3},{64,2}
    in_valid = 1; in_note = 60; in_dur = 3; step();
    in_note = 64; in_dur = 2; step();
    in_valid = 0;
    chk("push2_level", level, 2);
    start = 1; step(); start = 0;                 // edge N
    chk("n_busy", busy, 0);
    step();                                       // N+1: LOAD
    chk("load_busy", busy, 1);
    chk("load_note", note, 0);
    step();                                       // N+2
    chk("n2_note", note, 60);
    chk("n2_level", level, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("hold60", note, 60);
    end
    step();
    chk("first64", note, 64);
    chk("level_after_pop2", level, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("hold64", note, 64);
      chk("no_done_mid", done, 0);
    end
    step();
    chk("end_note", note, 0);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    step();
    chk("done_pulse_len", done, 0);
    stop = 1; step(); stop = 0;

    // full FIFO behaviour
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_note = 7'(10 + i); in_dur = 1; step();
    end
    chk("full_level", level, 4);
    chk("full_ready", in_ready, 0);
    in_note = 14; in_dur = 1; step();
    chk("refused_level", level, 4);
    start = 1; step(); start = 0;                 // N
    chk("full_n_level", level, 4);
    step();                                       // N+1 LOAD
    step();                                       // N+2 pop
    chk("pop_level", level, 3);
    chk("pop_ready", in_ready, 1);
    chk("pop_note", note, 10);
    step();                                       // N+3 push accepted
    in_valid = 0;
    chk("repush_level", level, 4);
    stop = 1; flush = 1; step(); stop = 0; flush = 0;
    chk("sf_note", note, 0);
    chk("sf_level", level, 0);
    chk("sf_busy", busy, 0);
    chk("sf_done", done, 0);

    // zero-duration entry skipped
    in_valid = 1; in_note = 60; in_dur = 0; step();
    in_note = 67; in_dur = 2; step();
    in_valid = 0;
    start = 1; step(); start = 0;                 // N
    step();                                       // N+1 LOAD
    step();                                       // N+2 skip
    chk("skip_note", note, 0);
    chk("skip_busy", busy, 1);
    step();                                       // N+3
    chk("skip67", note, 67);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("hold67", note, 67);
    end
    step();
    chk("skip_end_note", note, 0);
    chk("skip_end_done", done, 1);
    stop = 1; step(); stop = 0;

    // stop aborts, later start resumes with next entry
    in_valid = 1; in_note = 60; in_dur = 5; step();
    in_note = 62; in_dur = 5; step();
    in_valid = 0;
    start = 1; step(); start = 0;
    step(); step();
    chk("abort_note60", note, 60);
    for (int i = 0; i < 6; i++) step();
    chk("abort_pre", note, 60);
    stop = 1; step(); stop = 0;
    chk("abort_note", note, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_level", level, 1);
    step();
    chk("abort_done2", done, 0);
    start = 1; step(); start = 0;
    step(); step();
    chk("resume62", note, 62);
    chk("resume_level", level, 0);

    // asynchronous reset mid-PLAY
    step(); step(); step();
    chk("pre_rst_note", note, 62);
    rst = 1; #1;
    chk("async_note", note, 0);
    chk("async_level", level, 0);
    chk("async_busy", busy, 0);
    step();
    rst = 0;
    step();

    // articulation gap instance
    g_in_valid = 1; g_in_note = 60; g_in_dur = 1; step();
    g_in_note = 62; g_in_dur = 1; step();
    g_in_valid = 0;
    g_start = 1; step(); g_start = 0;             // N
    step(); step();                               // N+2
    chk("gap_60", g_note, 60);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_hold60", g_note, 60);
    end
    step();                                       // N+6
    chk("gap_rest", g_note, 0);
    chk("gap_busy", g_busy, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gap_rest_hold", g_note, 0);
      chk("gap_no_done", g_done, 0);
    end
    step();                                       // N+11
    chk("gap_62", g_note, 62);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_hold62", g_note, 62);
    end
    step();                                       // N+15: trailing gap
    chk("gap_tail_note", g_note, 0);
    chk("gap_tail_busy", g_busy, 1);
    chk("gap_tail_done", g_done, 0);
    for (int i = 0; i < 4; i++) step();           // N+19
    chk("gap_done", g_done, 1);
    chk("gap_idle", g_busy, 0);
    step();
    chk("gap_done_len", g_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Timed note source for the organ synthesizer. Buffers a queue of {note, duration} entries and plays them back one at a time. Drives the 7-bit `note` input of the single-note organ datapath, holding each note for a programmed number of ticks, with an optional silent articulation gap between notes. The block sits upstream of the note-to-FCW path and is loaded by the score/OMR front end through a valid/ready write port.

## Interface
- `CLK_PER_TICK`, 100000 — clock cycles per duration tick (1 ms at 100 MHz); ≥ 2
- `GAP_TICKS`, 0 — ticks of rest (note = 0) inserted after every note; 0 = legato
- `DEPTH`, 16 — entry FIFO depth; power of two, ≥ 2
- `DUR_W`, 8 — duration field width
- `clk` in 1 — system clock
- `rst` in 1 — asynchronous, active-high reset
- `in_valid` in 1 — write request for one entry
- `in_ready` out 1 — FIFO can accept; equals !full
- `in_note` in 7 — note code; 0 = rest (silence)
- `in_dur` in DUR_W — duration in ticks; 0 = skip entry
- `start` in 1 — set run flag (level or pulse)
- `stop` in 1 — clear run flag, abort current note
- `flush` in 1 — empty the FIFO
- `note` out 7 — registered note to synthesizer
- `busy` out 1 — state ≠ IDLE
- `done` out 1 — one-cycle pulse: queue drained naturally
- `level` out clog2(DEPTH+1) — entries in FIFO

## Operation
- FIFO stores {in_note, in_dur}. A push occurs when in_valid && in_ready. A write while full is ignored; in_ready is computed from the current count, so a push is refused on a full cycle even if a pop occurs on that same cycle.
- Run flag behaviour:
  - Set by `start`, cleared by `stop`.
  - `stop` has priority over `start` in the same cycle.
  - `stop` forces state to IDLE and `note` to 0 on the next edge. FIFO contents are kept; the aborted entry is lost.
- `flush` clears the FIFO (level → 0) and has priority over a simultaneous push. State is unaffected; the current note finishes.
- States:
  - IDLE: note = 0. Go to LOAD when run && level > 0.
  - LOAD (1 cycle): pop head.
    - If dur = 0: discard, stay in LOAD if level > 1, else return to IDLE.
    - Otherwise latch the entry, load the tick counter with dur, clear the prescaler, go to PLAY, and drive `note` ← entry note on the same edge.
  - PLAY: the prescaler counts 0..CLK_PER_TICK−1 and emits a tick at the terminal count. Each tick decrements the tick counter. The tick that takes the counter to 0 leaves PLAY:
    - to GAP if GAP_TICKS > 0 (note ← 0);
    - otherwise to LOAD if run && level > 0;
    - otherwise to IDLE (note ← 0, done pulse).
  - GAP: hold note = 0 for GAP_TICKS ticks. Then go to LOAD if run && level > 0, else to IDLE with a done pulse.
- In legato mode (GAP_TICKS = 0), `note` holds its previous value through the LOAD cycle, so there is no glitch to 0 between notes.
- Entries pushed while in PLAY become eligible at the next LOAD decision. The decision samples `level` on the deciding edge.
- `done` never pulses on a stop-abort or a flush.

## Timing
- Reset values: note = 0, busy = 0, done = 0, level = 0, in_ready = 1, run = 0, state = IDLE, prescaler = 0.
- `start` sampled at edge N with a non-empty FIFO:
  - LOAD at N+1;
  - `note` valid after edge N+2.
- In PLAY, each note is held for exactly dur × CLK_PER_TICK cycles.
- Legato note-to-note period is dur × CLK_PER_TICK + 1 cycles, because of the LOAD cycle.
- With a gap, the period is (dur + GAP_TICKS) × CLK_PER_TICK + 1 cycles.
- Each skipped (dur = 0) entry costs 1 cycle.
- `done` asserts on the edge that enters IDLE, for 1 cycle.
- `level` updates on the edge after the push or pop.

## Test plan
All tests use CLK_PER_TICK=4, DEPTH=4, GAP_TICKS=0 unless noted.
- Reset mid-PLAY: assert rst asynchronously → note = 0, level = 0, busy = 0 immediately, before the next clock edge.
- Push {60,3}, {64,2}, then pulse start:
  - note = 60 for 12 cycles, then 60 for 1 more LOAD cycle;
  - then 64 for 8 cycles;
  - then note = 0, with done high for exactly 1 cycle.
- GAP_TICKS=1, push {60,1}, {62,1}: 60 for 4 cycles → 0 for 4 + 1 cycles → 62 for 4 cycles → 0, done.
- Push 4 entries, so in_ready = 0. A 5th push with in_valid held is ignored and level stays at 4. After the first pop, in_ready = 1 and the next push is accepted.
- Push {60,0}, {67,2}, start → 60 is never driven; note = 67 appears after edge N+3 and lasts 8 cycles.
- Push {60,5}, {62,5}, start; assert stop 6 cycles into the note → note = 0 next edge, busy = 0, done = 0, level = 1. A later start plays 62.
